muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide sequencer beside the execute stage. Accepts one M-extension operation from execute, computes it over multiple cycles on a single shared shift/add-subtract datapath, and holds execute through the hazard logic until the result is ready. One operation in flight at a time. Killed operations are discarded without side effects.

---
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer sharing one shift/add-subtract datapath.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplies, divides stay iterative.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  input  logic            stall_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic            done_q, done_d;

  // Operand decode for the accept cycle
  logic            sgn_a, sgn_b, div0, ovf;
  logic [XLEN-1:0] abs_a, abs_b, special;
  always_comb begin
    sgn_a   = rs1[XLEN-1] & (op[2] ? ~op[0] : (op != 3'd3));
    sgn_b   = rs2[XLEN-1] & (op[2] ? ~op[0] : (op[2:1] == 2'b00));
    abs_a   = sgn_a ? -rs1 : rs1;
    abs_b   = sgn_b ? -rs2 : rs2;
    div0    = op[2] && (rs2 == '0);
    ovf     = op[2] && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    special = div0 ? (op[1] ? rs1 : '1) : (op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  always_comb
    fast_prod = {{XLEN{sgn_a}}, rs1} * {{XLEN{rs2[XLEN-1] & (op[2:1] == 2'b00)}}, rs2};
`endif

  // Shared adder: adds multiplicand for multiply, subtracts divisor for divide
  logic            is_div;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] add_a, add_b, sum;
  logic [XLEN:0]   acc;
  always_comb begin
    is_div  = op_q[2];
    shifted = {hi_q, lo_q[XLEN-1]};
    add_a   = is_div ? {1'b0, shifted} : {2'b00, hi_q};
    add_b   = is_div ? ~{2'b00, m_q} : {2'b00, m_q};
    sum     = add_a + add_b + {{(XLEN+1){1'b0}}, is_div};
    acc     = lo_q[0] ? sum[XLEN:0] : {1'b0, hi_q};
  end

  logic [2*XLEN-1:0] prod_n;
  logic [XLEN-1:0]   qr, qr_n;
  always_comb begin
    prod_n = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    qr     = op_q[1] ? hi_q : lo_q;
    qr_n   = neg_q ? -qr : qr;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: if (start && !kill) begin
        op_d  = op;
        neg_d = (op == 3'd6) ? sgn_a : (sgn_a ^ sgn_b);
        cnt_d = '0;
        if (div0 || ovf) begin
          result_d = special;
          state_d  = DONE;
`ifdef MULDIV_FAST_MUL_EN
        end else if (!op[2]) begin
          result_d = (op == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
          state_d  = DONE;
`endif
        end else begin
          m_d     = op[2] ? abs_b : abs_a;
          lo_d    = op[2] ? abs_a : abs_b;
          hi_d    = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (is_div) begin
          hi_d = sum[XLEN+1] ? shifted[XLEN-1:0] : sum[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], ~sum[XLEN+1]};
        end else begin
          {hi_d, lo_d} = {acc, lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIXUP;
      end
      FIXUP: begin
        result_d = op_q[2] ? qr_n : ((op_q == 3'd0) ? prod_n[XLEN-1:0] : prod_n[2*XLEN-1:XLEN]);
        state_d  = DONE;
      end
      DONE: if (!stall_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = ((state_q == IDLE) && start && !kill) || (state_q == CALC) || (state_q == FIXUP);
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 0, reset = 1, start = 0, kill = 0, stall_in = 0;
  logic [2:0]  op = 0;
  logic [31:0] rs1 = 0, rs2 = 0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .kill(kill), .stall_in(stall_in), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] res; int lat; int acc; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a)); sb_ = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    ia = a; ib = b;
    case (o)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            else return ia / ib;
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            else return ia % ib;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return 34;
  endfunction

  // Monitor: pops on the first DONE cycle of each op, then checks result holds
  logic [31:0] held;
  logic done_prev = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: got done=1 want no pending op (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          held = result;
        end
      end else if (done && done_prev) begin
        chk("hold", result, held);
      end
    end
    done_prev = done;
  end

  // Called between a negedge and the next posedge with the unit idle
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input bit push);
    exp_t e;
    op = o; rs1 = a; rs2 = b; start = 1;
    if (push) begin
      e.res = exp_res; e.lat = ref_lat(o, a, b); e.acc = cyc;
      sb.push_back(e);
    end
    #1 chk("busy_accept", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 0; rs1 = $urandom; rs2 = $urandom;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("timeout_done", 32'(t), 32'd0);
    t = 0;
    while (done && t < 100) begin @(negedge clk); t++; end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    issue(o, a, b, r, 1'b1);
    wait_done();
  endtask

  initial begin
    int n;
    logic [2:0] o;
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);

    run(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF);
    run(3'd7, 32'd5, 32'd0, 32'd5);
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    run(3'd1, 32'h80000000, 32'h80000000, 32'h40000000);

    // Kill mid-CALC, then re-accept in the very next cycle
    issue(3'd5, 32'd100, 32'd7, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    kill = 1;
    @(negedge clk);
    kill = 0;
    #1;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_done", {31'b0, done}, 32'd0);
    run(3'd5, 32'd100, 32'd7, 32'd14);

    // Stall in DONE stretches done over four cycles
    stall_in = 1;
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (done && n < 10) begin
      n++;
      chk("stall_busy", {31'b0, busy}, 32'd0);
      if (n == 4) stall_in = 0;
      @(negedge clk);
    end
    chk("stall_done_cycles", 32'(n), 32'd4);
    chk("stall_idle_busy", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = $urandom_range(1, 3);
        default: ;
      endcase
      run(o, a, b, ref_res(o, a, b));
    end

    repeat (2) @(negedge clk);
    chk("pending", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
